// File: rtl/io_packet_rx.sv
// rtl/io_packet_rx.sv - UART byte stream to AGC channel-write framer.
// Define IO_PKT_CHECKSUM_EN to require a fourth XOR checksum byte per packet.
module io_packet_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [4:0]  pkt_sel,
  output logic [14:0] pkt_data,
  output logic        pkt_valid,
  output logic        busy,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter never holds TIMEOUT_CYCLES-1: the increment that would reach it fires the timeout.
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 2);

`ifdef IO_PKT_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GOT_HDR, ST_GOT_HI, ST_GOT_LO} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_GOT_HDR, ST_GOT_HI} state_t;
`endif

  state_t        state_q, state_d;
  logic [4:0]    sel_q, sel_d;
  logic [6:0]    hi_q, hi_d;
  logic [4:0]    pkt_sel_q, pkt_sel_d;
  logic [14:0]   pkt_data_q, pkt_data_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          is_hdr;
`ifdef IO_PKT_CHECKSUM_EN
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    csum;
`endif

  assign is_hdr = (rx_data[7:5] == 3'b100);
`ifdef IO_PKT_CHECKSUM_EN
  assign csum = {3'b100, sel_q} ^ {1'b0, hi_q} ^ lo_q;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hi_d        = hi_q;
    pkt_sel_d   = pkt_sel_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = 1'b0;
    err_d       = 1'b0;
`ifdef IO_PKT_CHECKSUM_EN
    lo_d        = lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && is_hdr) begin
          sel_d   = rx_data[4:0];
          state_d = ST_GOT_HDR;
        end
      end
      ST_GOT_HDR: begin
        if (rx_valid) begin
          if (!rx_data[7]) begin
            hi_d    = rx_data[6:0];
            state_d = ST_GOT_HI;
          end else begin
            err_d = 1'b1;
            if (is_hdr) sel_d = rx_data[4:0];
            else        state_d = ST_IDLE;
          end
        end
      end
      ST_GOT_HI: begin
        if (rx_valid) begin
`ifdef IO_PKT_CHECKSUM_EN
          lo_d    = rx_data;
          state_d = ST_GOT_LO;
`else
          pkt_sel_d   = sel_q;
          pkt_data_d  = {hi_q, rx_data};
          pkt_valid_d = 1'b1;
          state_d     = ST_IDLE;
`endif
        end
      end
`ifdef IO_PKT_CHECKSUM_EN
      ST_GOT_LO: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            pkt_sel_d   = sel_q;
            pkt_data_d  = {hi_q, lo_q};
            pkt_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving in the timeout cycle takes precedence over the timeout.
    if (state_q != ST_IDLE && !rx_valid && gap_q == GAP_LAST) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    gap_d     = (rx_valid || state_d == ST_IDLE) ? '0 : gap_q + 1'b1;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      hi_q        <= '0;
      pkt_sel_q   <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      gap_q       <= '0;
`ifdef IO_PKT_CHECKSUM_EN
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hi_q        <= hi_d;
      pkt_sel_q   <= pkt_sel_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      gap_q       <= gap_d;
`ifdef IO_PKT_CHECKSUM_EN
      lo_q        <= lo_d;
`endif
    end
  end

  assign pkt_sel   = pkt_sel_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_pulse = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_io_packet_rx.sv
// tb/tb_io_packet_rx.sv - randomized bench for io_packet_rx against a packet-level model.
module tb_io_packet_rx;
  localparam int T = 16;
`ifdef IO_PKT_CHECKSUM_EN
  localparam int PLEN = 4;
`else
  localparam int PLEN = 3;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [4:0]  pkt_sel;
  logic [14:0] pkt_data;
  logic        pkt_valid;
  logic        busy;
  logic        err_pulse;
  logic [7:0]  err_count;

  io_packet_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pkt_sel(pkt_sel), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .busy(busy), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [7:0] pend[$];
  int         idle_run;
  logic [4:0] exp_sel;
  logic [14:0] exp_data;
  logic       exp_valid, exp_err;
  int         exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit header_byte(input logic [7:0] b);
    return b[7] && b[6:5] == 2'b00;
  endfunction

  task automatic model_err();
    exp_err = 1'b1;
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic [7:0] ck;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (v) begin
      idle_run = 0;
      if (pend.size() == 0) begin
        if (header_byte(d)) pend.push_back(d);
      end else if (pend.size() == 1 && d[7]) begin
        model_err();
        pend.delete();
        if (header_byte(d)) pend.push_back(d);
      end else begin
        pend.push_back(d);
        if (pend.size() == PLEN) begin
          ck = pend[0] ^ pend[1] ^ pend[2];
          if (PLEN == 3 || d == ck) begin
            exp_valid = 1'b1;
            exp_sel   = pend[0][4:0];
            exp_data  = {pend[1][6:0], pend[2]};
          end else begin
            model_err();
          end
          pend.delete();
        end
      end
    end else if (pend.size() > 0) begin
      idle_run++;
      if (idle_run == T - 1) begin
        model_err();
        pend.delete();
        idle_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("pkt_valid", pkt_valid, exp_valid);
    chk("err_pulse", err_pulse, exp_err);
    chk("busy", busy, pend.size() > 0);
    chk("err_count", err_count, exp_cnt);
    chk("pkt_sel", pkt_sel, exp_sel);
    chk("pkt_data", pkt_data, exp_data);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_step(v, d);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    pend.delete();
    idle_run  = 0;
    exp_sel   = '0;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = 0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  task automatic send_pkt(input logic [4:0] sel, input logic [14:0] data);
    logic [7:0] h, d1, d0;
    h  = {3'b100, sel};
    d1 = {1'b0, data[14:8]};
    d0 = data[7:0];
    cycle(1'b1, h);
    cycle(1'b1, d1);
    cycle(1'b1, d0);
    if (PLEN == 4) cycle(1'b1, h ^ d1 ^ d0);
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] b;
    model_reset();
    #2;
    compare_all();
    @(posedge clock);
    #1;
    do_reset();

    // Literal pins: good packet.
    send_pkt(5'd5, 15'h0123);
    chk("lit_sel5", pkt_sel, 32'd5);
    chk("lit_data0123", pkt_data, 32'h0123);
    chk("lit_valid", pkt_valid, 32'd1);
    chk("lit_cnt0", err_count, 32'd0);
    cycle(1'b0, 8'h00);
    chk("lit_valid_one_cycle", pkt_valid, 32'd0);

    // Resync on a second header.
    cycle(1'b1, 8'h81);
    cycle(1'b1, 8'h82);
    chk("lit_resync_err", err_pulse, 32'd1);
    chk("lit_resync_busy", busy, 32'd1);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h37);
    if (PLEN == 4) cycle(1'b1, 8'h82 ^ 8'h00 ^ 8'h37);
    chk("lit_resync_sel", pkt_sel, 32'd2);
    chk("lit_resync_data", pkt_data, 32'h0037);
    chk("lit_resync_cnt", err_count, 32'd1);

`ifdef IO_PKT_CHECKSUM_EN
    cycle(1'b1, 8'h9F); cycle(1'b1, 8'h7F); cycle(1'b1, 8'hFF); cycle(1'b1, 8'h1F);
    chk("lit_ck_sel", pkt_sel, 32'd31);
    chk("lit_ck_data", pkt_data, 32'h7FFF);
    cycle(1'b1, 8'h9F); cycle(1'b1, 8'h7F); cycle(1'b1, 8'hFF); cycle(1'b1, 8'h00);
    chk("lit_badck_valid", pkt_valid, 32'd0);
    chk("lit_badck_err", err_pulse, 32'd1);
    chk("lit_badck_cnt", err_count, 32'd2);
    chk("lit_badck_hold", pkt_data, 32'h7FFF);
`endif

    // Timeout after a lone header.
    cycle(1'b1, 8'h83);
    n = 0;
    while (!err_pulse && n < 40) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("lit_timeout_gap", n, 32'd15);
    chk("lit_timeout_busy", busy, 32'd0);
    send_pkt(5'd9, 15'h1A5C);
    chk("lit_after_to_data", pkt_data, 32'h1A5C);

    // Byte in the would-be timeout cycle wins.
    cycle(1'b1, 8'h84);
    for (int i = 0; i < T - 2; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h12);
    chk("lit_byte_wins", err_pulse, 32'd0);
    for (int i = 0; i < T; i++) cycle(1'b0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        for (int k = 0; k < 18; k++) cycle(1'b0, 8'h00);
      end
      r = $urandom_range(0, 9);
      if (r <= 2)      b = {3'b100, 5'($urandom_range(0, 31))};
      else if (r == 3) b = 8'($urandom_range(0, 255)) | 8'hA0;
      else if (r <= 6) b = {1'b0, 7'($urandom_range(0, 127))};
      else             b = 8'($urandom_range(0, 255));
      if (pend.size() == 3 && $urandom_range(0, 1) == 1) b = pend[0] ^ pend[1] ^ pend[2];
      cycle($urandom_range(0, 3) != 0, b);
    end

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 8'h83);
      for (int k = 0; k < T - 1; k++) cycle(1'b0, 8'h00);
    end
    chk("lit_saturate", err_count, 32'd255);

    // Reset mid-packet.
    cycle(1'b1, 8'h86);
    cycle(1'b1, 8'h05);
    do_reset();
    chk("lit_rst_busy", busy, 32'd0);
    chk("lit_rst_cnt", err_count, 32'd0);
    chk("lit_rst_data", pkt_data, 32'd0);
    send_pkt(5'd17, 15'h2BCD);
    chk("lit_post_rst_sel", pkt_sel, 32'd17);
    chk("lit_post_rst_data", pkt_data, 32'h2BCD);
    cycle(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
